dist_sq_unit: RTL and testbench
===============================

Name: dist_sq_unit

Overview:
- Upstream stage of fast_inv_sqrt in the gravity pipeline. Takes one body-pair displacement (dx, dy, dz) and produces r² = dx² + dy² + dz², plus an optional softening term.
- All values use the 27-bit float format consumed by fast_inv_sqrt:
  - [26] sign
  - [25:18] exponent, bias 127
  - [17:0] fraction, hidden leading 1
- One shared squarer and adder are used sequentially, one component per cycle. Valid/ready handshake on both sides.

Parameters:
- EPS_SQ, 27'h1FC0000 (1.0), softening constant added when SOFTENING_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  dx/dy/dz valid
- in_ready  out  1  block can accept
- dx  in  27  x displacement, float27
- dy  in  27  y displacement, float27
- dz  in  27  z displacement, float27
- out_valid  out  1  r_sq valid
- out_ready  in  1  downstream accepts r_sq
- r_sq  out  27  squared distance, float27, sign always 0
- ovf  out  1  sticky: a saturation occurred since reset

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, accumulator=0, count=0.
  - out_valid=0, r_sq=0, ovf=0, in_ready=1 once rst rises.
  - Any in-flight computation is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge N: latch dx/dy/dz, acc<=0, count<=0, go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: acc <= fadd(acc, fsq(operand[count])), count++. Operand order is dx, dy, dz, then EPS_SQ (if enabled, added directly, not squared).
  - After the last step, go to DONE.
  - Without SOFTENING_EN: 3 steps, out_valid rises after edge N+3.
  - With SOFTENING_EN: 4 steps, out_valid rises after edge N+4.
- DONE:
  - out_valid=1, r_sq=acc, held stable until out_valid&&out_ready.
  - On handshake: out_valid<=0, go to IDLE.
  - in_ready stays 0 in the handshake cycle, so there is no same-edge accept. Next accept is one cycle later at the earliest.
  - in_valid while busy is ignored; the upstream holds it.
- fsq(x), square:
  - Sign ignored.
  - If exp==0: result 0 (denormals flushed).
  - e=2*exp-127. Mantissa product is {1,frac}×{1,frac}, 38 bits. If product bit 37 is set, shift right 1 and e++.
  - Fraction is truncated to 18 bits.
  - e<=0: result 0.
  - e>=255: result 27'h3FBFFFF (max finite), and set ovf.
- fadd(a,b), both operands non-negative:
  - A zero operand returns the other operand.
  - Otherwise: align the smaller exponent right and truncate shifted-out bits. Shifts of ≥19 make that operand zero.
  - Add the 20-bit mantissas. On carry, shift right 1 and exp++.
  - Fraction is truncated.
  - exp reaching 255: saturate to 27'h3FBFFFF and set ovf.
- No rounding anywhere; truncation only. No NaN/Inf generation.

Optional Feature:
- Macro SOFTENING_EN.
- Defined: a fourth CALC step adds EPS_SQ, so latency is 4 cycles; r_sq is never 0.
- Undefined: 3 steps, latency 3; EPS_SQ is unused.

Test Plan:
- dx=27'h1FC0000 (1.0), dy=dz=27'h2000000 (2.0), SOFTENING_EN off -> r_sq=27'h2088000 (9.0); out_valid exactly 3 cycles after the accept edge.
- dx=27'h6020000 (-3.0), dy=dz=0 -> r_sq=27'h2088000 (9.0), sign bit 0; all-zero inputs -> r_sq=0.
- dx exponent 200, dy=dz=0 -> r_sq=27'h3FBFFFF, ovf=1 and stays 1 across later transactions. dx exponent 50 -> r_sq=0, ovf unchanged.
- Hold out_ready=0 for 5 cycles in DONE -> r_sq and out_valid stable, in_ready=0, new in_valid ignored. Release -> exactly one transfer, in_ready=1 the following cycle.
- SOFTENING_EN on, EPS_SQ=1.0, inputs 1,2,2 -> r_sq=27'h2090000 (10.0), latency 4.
- Drop rst low during CALC -> out_valid=0, r_sq=0, ovf=0 immediately. After release, a fresh transaction gives the correct result.

Source files
------------

// File: rtl/dist_sq_unit.sv
// rtl/dist_sq_unit.sv - squared distance r^2 = dx^2 + dy^2 + dz^2 (+ EPS_SQ) in float27
//
// Purpose:
//   Upstream stage of fast_inv_sqrt. One squarer and one adder are shared and
//   stepped once per cycle over dx, dy, dz (and EPS_SQ when SOFTENING_EN is
//   defined). Float27 layout: [26] sign, [25:18] exponent (bias 127),
//   [17:0] fraction with hidden leading 1. Truncation only, no rounding.
//
// Optional feature:
//   `define SOFTENING_EN adds EPS_SQ (not squared) as a fourth step, giving
//   a latency of 4 instead of 3.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   dx/dy/dz valid
//   in_ready   out  block can accept a new displacement
//   dx/dy/dz   in   displacement components, float27
//   out_valid  out  r_sq valid, held until out_ready
//   out_ready  in   downstream accepts r_sq
//   r_sq       out  squared distance, float27, sign always 0
//   ovf        out  sticky: a saturation occurred since reset

module dist_sq_unit #(
    parameter logic [26:0] EPS_SQ = 27'h1FC0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] dx,
    input  logic [26:0] dy,
    input  logic [26:0] dz,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] r_sq,
    output logic        ovf
);

    localparam logic [26:0] SAT = 27'h3FBFFFF;

`ifdef SOFTENING_EN
    localparam logic [1:0] LAST_STEP = 2'd3;
`else
    localparam logic [1:0] LAST_STEP = 2'd2;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [25:0] r_dx, r_dy, r_dz;   // sign dropped: only squares are taken
    logic [26:0] r_acc;
    logic [1:0]  r_count;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_ovf;

    // Operand select for the shared squarer.
    logic [25:0] w_op;
    always_comb begin
        case (r_count)
            2'd0:    w_op = r_dx;
            2'd1:    w_op = r_dy;
            default: w_op = r_dz;
        endcase
    end

    // Squarer. The exponent is kept biased by +127 (w_sq_eb = 2*exp + carry)
    // so the underflow/overflow tests stay unsigned.
    logic [18:0] w_sq_m;
    logic [37:0] w_sq_prod;
    logic [9:0]  w_sq_eb;
    logic [9:0]  w_sq_sub;
    logic [17:0] w_sq_f;
    logic [26:0] w_sq;
    logic        w_sq_ovf;

    assign w_sq_m = {1'b1, w_op[17:0]};

    always_comb begin
        w_sq_prod = {19'd0, w_sq_m} * {19'd0, w_sq_m};
        w_sq_eb   = {1'b0, w_op[25:18], 1'b0} + {9'd0, w_sq_prod[37]};
        w_sq_sub  = w_sq_eb - 10'd127;
        w_sq_f    = w_sq_prod[37] ? w_sq_prod[36:19] : w_sq_prod[35:18];
        w_sq      = '0;
        w_sq_ovf  = 1'b0;
        if (w_op[25:18] == 8'd0 || w_sq_eb <= 10'd127) begin
            w_sq = '0;
        end else if (w_sq_eb >= 10'd382) begin
            w_sq     = SAT;
            w_sq_ovf = 1'b1;
        end else begin
            w_sq = {1'b0, w_sq_sub[7:0], w_sq_f};
        end
    end

    // The softening step bypasses the squarer.
    logic [26:0] w_b;
    logic        w_b_ovf;
    assign w_b     = (r_count == 2'd3) ? EPS_SQ : w_sq;
    assign w_b_ovf = (r_count != 2'd3) && w_sq_ovf;

    // Adder for non-negative operands.
    logic [7:0]  w_big_e, w_sml_e, w_diff;
    logic [17:0] w_big_f, w_sml_f;
    logic [18:0] w_sml_m;
    logic [19:0] w_sum;
    logic [8:0]  w_add_e;
    logic [17:0] w_add_f;
    logic [26:0] w_add;
    logic        w_add_ovf;

    always_comb begin
        if (r_acc[25:18] >= w_b[25:18]) begin
            w_big_e = r_acc[25:18];
            w_big_f = r_acc[17:0];
            w_sml_e = w_b[25:18];
            w_sml_f = w_b[17:0];
        end else begin
            w_big_e = w_b[25:18];
            w_big_f = w_b[17:0];
            w_sml_e = r_acc[25:18];
            w_sml_f = r_acc[17:0];
        end
        w_diff  = w_big_e - w_sml_e;
        // Shifts of 19 or more would flush the whole mantissa anyway.
        w_sml_m = (w_diff >= 8'd19) ? 19'd0 : ({1'b1, w_sml_f} >> w_diff);
        w_sum   = {2'b01, w_big_f} + {1'b0, w_sml_m};
        if (w_sum[19]) begin
            w_add_e = {1'b0, w_big_e} + 9'd1;
            w_add_f = w_sum[18:1];
        end else begin
            w_add_e = {1'b0, w_big_e};
            w_add_f = w_sum[17:0];
        end
        w_add     = '0;
        w_add_ovf = 1'b0;
        if (r_acc[25:18] == 8'd0) begin
            w_add = w_b;
        end else if (w_b[25:18] == 8'd0) begin
            w_add = r_acc;
        end else if (w_add_e >= 9'd255) begin
            w_add     = SAT;
            w_add_ovf = 1'b1;
        end else begin
            w_add = {1'b0, w_add_e[7:0], w_add_f};
        end
    end

    logic w_unused;
    assign w_unused = ^{dx[26], dy[26], dz[26], w_sq_prod[17:0], w_sq_sub[9:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dx        <= '0;
            r_dy        <= '0;
            r_dz        <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_dx       <= dx[25:0];
                        r_dy       <= dy[25:0];
                        r_dz       <= dz[25:0];
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_acc   <= w_add;
                    r_count <= r_count + 2'd1;
                    if (w_b_ovf || w_add_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_count == LAST_STEP) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, so no
                    // accept can coincide with the output transfer.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign r_sq      = r_acc;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_dist_sq_unit.sv
// tb/tb_dist_sq_unit.sv - directed self-checking bench for dist_sq_unit

module tb_dist_sq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [26:0] dx = '0;
    logic [26:0] dy = '0;
    logic [26:0] dz = '0;
    logic        in_ready;
    logic        out_valid;
    logic [26:0] r_sq;
    logic        ovf;

    localparam logic [26:0] F_ONE   = 27'h1FC0000;
    localparam logic [26:0] F_TWO   = 27'h2000000;
    localparam logic [26:0] F_M3    = 27'h6020000;
    localparam logic [26:0] F_MAXM  = 27'h1FFFFFF;
    localparam logic [26:0] F_E200  = 27'h3200000;
    localparam logic [26:0] F_E50   = 27'h0C80000;
    localparam logic [26:0] SAT     = 27'h3FBFFFF;

`ifdef SOFTENING_EN
    localparam int          LAT     = 4;
    localparam logic [26:0] E_122   = 27'h2090000;
    localparam logic [26:0] E_ZERO  = 27'h1FC0000;
    localparam logic [26:0] E_MAXM  = 27'h204FFFF;
`else
    localparam int          LAT     = 3;
    localparam logic [26:0] E_122   = 27'h2088000;
    localparam logic [26:0] E_ZERO  = 27'h0000000;
    localparam logic [26:0] E_MAXM  = 27'h203FFFE;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    dist_sq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dx        (dx),
        .dy        (dy),
        .dz        (dz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_sq      (r_sq),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("send_in_ready", in_ready, 1);
        dx = a; dy = b; dz = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ov_after"}, out_valid, 0);
        check({tag, "_rdy_after"}, in_ready, 1);
    endtask

    task automatic do_txn(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c,
                          input logic [26:0] e, input string tag);
        int lat;
        send(a, b, c);
        wait_done(lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_rsq"}, r_sq, e);
        handshake(tag);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_r_sq", r_sq, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        do_txn(F_ONE, F_TWO, F_TWO, E_122, "t122");
        check("t122_ovf", ovf, 0);
        do_txn(F_M3, 27'd0, 27'd0, E_122, "tneg3");
        check("tneg3_sign", r_sq[26], 0);
        do_txn(27'd0, 27'd0, 27'd0, E_ZERO, "tzero");
        do_txn(F_MAXM, 27'd0, 27'd0, E_MAXM, "ttrunc");

        // Stall in DONE while upstream offers a vector that would saturate.
        send(F_ONE, F_TWO, F_TWO);
        wait_done(lat);
        check("hold_lat", lat, LAT);
        dx = F_E200; dy = '0; dz = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_r_sq", r_sq, E_122);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("rel_out_valid", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_no_accept", in_ready, 1);
        check("rel_ovf_clean", ovf, 0);

        do_txn(F_E200, 27'd0, 27'd0, SAT, "tsat");
        check("tsat_ovf", ovf, 1);
        do_txn(F_E50, 27'd0, 27'd0, E_ZERO, "tunder");
        check("tunder_ovf", ovf, 1);
        do_txn(F_ONE, F_TWO, F_TWO, E_122, "tsticky");
        check("tsticky_ovf", ovf, 1);

        // Asynchronous reset in the middle of CALC.
        send(F_ONE, F_TWO, F_TWO);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_r_sq", r_sq, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        do_txn(F_ONE, F_TWO, F_TWO, E_122, "tfresh");
        check("tfresh_ovf", ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
